demux16_steer: RTL and testbench

Registered 1-to-2 word router for the CPU datapath. It accepts a 16-bit word stream with a select bit and steers each word into one of two buffered output channels, A or B. Each channel has its own valid/ready handshake and a small FIFO. It is the inverse of the 2:1 16-bit word selector: one source feeds two sinks instead of two sources feeding one sink.

---
 rtl/demux16_pkg.sv | 7 +
 rtl/demux16_fifo.sv | 60 ++++++
 rtl/demux16_steer.sv | 49 ++++
 tb/tb_demux16_steer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/demux16_pkg.sv
// demux16_pkg: shared types and constants for the demux16_steer word router
package demux16_pkg;
  typedef logic [15:0] word_t;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_state_t;
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/demux16_fifo.sv
// demux16_fifo: one output channel FIFO with occupancy FSM and registered head; optional pop counter under DEMUX16_COUNT_EN
module demux16_fifo
  import demux16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             full
`ifdef DEMUX16_COUNT_EN
  ,
  output logic [7:0]       count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic [OW-1:0] occ, occ_nxt;
  occ_state_t state, state_nxt;
  logic pop;
  assign pop  = valid && ready;
  assign full = state == FULL;
  always_comb begin
    rd_nxt    = rd_ptr + AW'(pop);
    occ_nxt   = occ + OW'(push) - OW'(pop);
    state_nxt = occ_nxt == '0 ? EMPTY : occ_nxt == OW'(DEPTH) ? FULL : PARTIAL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      occ    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      valid  <= 1'b0;
      data   <= '0;
    end else begin
      state  <= state_nxt;
      occ    <= occ_nxt;
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_ptr + AW'(push);
      valid  <= state_nxt != EMPTY;
      // the next head is the incoming word only when it lands in the slot the read pointer moves to
      data   <= state_nxt == EMPTY ? '0 : (push && wr_ptr == rd_nxt) ? wdata : mem[rd_nxt];
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= wdata;
`ifdef DEMUX16_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else count <= count + 8'(pop);
  end
`endif
endmodule

// File: rtl/demux16_steer.sv
// demux16_steer: 1-to-2 registered word router into two FIFO channels; DEMUX16_COUNT_EN adds per-channel pop counters
module demux16_steer
  import demux16_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready
`ifdef DEMUX16_COUNT_EN
  ,
  output logic [7:0]       a_count,
  output logic [7:0]       b_count
`endif
);
  logic live, a_full, b_full, a_push, b_push;
  // holds in_ready low through reset and until the first clock after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else live <= 1'b1;
  end
  assign in_ready = live && !(in_sel == SEL_B ? b_full : a_full);
  assign a_push   = in_valid && in_ready && in_sel == SEL_A;
  assign b_push   = in_valid && in_ready && in_sel == SEL_B;
  demux16_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_a (
    .clk(clk), .rst_n(rst_n), .push(a_push), .wdata(in_data), .ready(a_ready),
    .valid(a_valid), .data(a_data), .full(a_full)
`ifdef DEMUX16_COUNT_EN
    , .count(a_count)
`endif
  );
  demux16_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_b (
    .clk(clk), .rst_n(rst_n), .push(b_push), .wdata(in_data), .ready(b_ready),
    .valid(b_valid), .data(b_data), .full(b_full)
`ifdef DEMUX16_COUNT_EN
    , .count(b_count)
`endif
  );
endmodule

// File: tb/tb_demux16_steer.sv
// tb_demux16_steer: scoreboard bench for demux16_steer with randomized streaming and directed corner cases
module tb_demux16_steer;
  localparam int DEPTH = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] in_data = '0, a_data, b_data;
  logic in_sel = 1'b0, in_valid = 1'b0, in_ready;
  logic a_valid, b_valid, a_ready = 1'b0, b_ready = 1'b0;
`ifdef DEMUX16_COUNT_EN
  logic [7:0] a_count, b_count;
`endif
  int checks = 0, errors = 0;
  logic [15:0] qa[$], qb[$];
  logic [7:0] ea = '0, eb = '0;
  bit mon_en = 1'b0;

  demux16_steer #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready)
`ifdef DEMUX16_COUNT_EN
    , .a_count(a_count), .b_count(b_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive one cycle; the model says a word is accepted iff its channel holds fewer than DEPTH words
  task automatic cycle(input logic v, input logic s, input logic [15:0] d, input logic ar, input logic br);
    int occ;
    logic acc;
    @(negedge clk);
    in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    #1;
    occ = s ? qb.size() : qa.size();
    chk("in_ready", 32'(in_ready), 32'(occ < DEPTH));
    acc = v && (occ < DEPTH);
    #2;
    if (acc) begin
      if (s) qb.push_back(d);
      else qa.push_back(d);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
      chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
      if (qa.size() != 0) chk("a_data", 32'(a_data), 32'(qa[0]));
      else chk("a_data_idle", 32'(a_data), 32'h0);
      if (qb.size() != 0) chk("b_data", 32'(b_data), 32'(qb[0]));
      else chk("b_data_idle", 32'(b_data), 32'h0);
`ifdef DEMUX16_COUNT_EN
      chk("a_count", 32'(a_count), 32'(ea));
      chk("b_count", 32'(b_count), 32'(eb));
`endif
      if (qa.size() != 0 && a_ready) begin void'(qa.pop_front()); ea++; end
      if (qb.size() != 0 && b_ready) begin void'(qb.pop_front()); eb++; end
    end
  end

  task automatic check_reset_state();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_a_valid", 32'(a_valid), 32'h0);
    chk("rst_b_valid", 32'(b_valid), 32'h0);
    chk("rst_a_data", 32'(a_data), 32'h0);
    chk("rst_b_data", 32'(b_data), 32'h0);
`ifdef DEMUX16_COUNT_EN
    chk("rst_a_count", 32'(a_count), 32'h0);
    chk("rst_b_count", 32'(b_count), 32'h0);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    // basic steer
    cycle(1, 0, 16'hA5A5, 1, 1);
    cycle(1, 1, 16'h5A5A, 1, 1);
    repeat (2) cycle(0, 0, 16'h0, 1, 1);
    // A backpressured until full, B still accepted, then full push with simultaneous pop
    cycle(1, 0, 16'h0001, 0, 1);
    cycle(1, 0, 16'h0002, 0, 1);
    cycle(1, 0, 16'h0003, 0, 1);
    cycle(1, 1, 16'hBBBB, 0, 1);
    cycle(1, 0, 16'h0004, 1, 1);
    cycle(1, 0, 16'h0005, 1, 1);
    repeat (4) cycle(0, 0, 16'h0, 1, 1);
    // random streaming with sink stalls
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)), 16'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    repeat (DEPTH + 2) cycle(0, 0, 16'h0, 1, 1);
    chk("drain_a", 32'(qa.size()), 32'h0);
    chk("drain_b", 32'(qb.size()), 32'h0);
    // reset with both channels holding words
    cycle(1, 0, 16'h1111, 0, 0);
    cycle(1, 1, 16'h2222, 0, 0);
    cycle(1, 0, 16'h3333, 0, 0);
    @(negedge clk);
    mon_en = 1'b0;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    qa.delete(); qb.delete();
    ea = '0; eb = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) cycle(0, 0, 16'h0, 1, 1);
`ifdef DEMUX16_COUNT_EN
    for (int i = 0; i < 257; i++) cycle(1, 1, 16'(i), 1, 1);
    repeat (3) cycle(0, 0, 16'h0, 1, 1);
    chk("b_count_wrap", 32'(b_count), 32'h1);
    chk("a_count_same", 32'(a_count), 32'h0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
